// File: rtl/muxn_rr.sv
// Registered N:1 channel multiplexer with a manual-select mode and a
// round-robin mode. Uses a valid/ready output register and a one-hot grant to the sources.
module muxn_rr #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] a,
  input  logic [N-1:0]       valid_in,
  input  logic               mode,
  input  logic [SW-1:0]      s,
  output logic [N-1:0]       grant,
  output logic [WIDTH-1:0]   y,
  output logic               y_valid,
  output logic [SW-1:0]      y_sel,
  input  logic               y_ready
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [SW-1:0]    y_sel_q, y_sel_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic             load;
  logic             found;
  int               idx;

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_sel_d   = y_sel_q;
    ptr_d     = ptr_q;
    grant     = '0;
    found     = 1'b0;
    idx       = 0;
    load      = !y_valid_q || y_ready;

    if (!rst && load) begin
      if (!mode) begin
        // Select values with no matching channel (s >= N) yield an empty word.
        y_d       = '0;
        y_sel_d   = s;
        y_valid_d = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (s == SW'(k)) begin
            y_d       = a[k*WIDTH +: WIDTH];
            y_valid_d = valid_in[k];
            grant[k]  = valid_in[k];
          end
        end
      end else begin
        y_valid_d = 1'b0;
        // Scan starting at ptr, wrapping modulo N; the first requester wins.
        for (int i = 0; i < N; i++) begin
          if (!found && valid_in[(int'(ptr_q) + i) % N]) begin
            found = 1'b1;
            idx   = (int'(ptr_q) + i) % N;
          end
        end
        if (found) begin
          y_d        = a[idx*WIDTH +: WIDTH];
          y_sel_d    = SW'(idx);
          y_valid_d  = 1'b1;
          grant[idx] = 1'b1;
          ptr_d      = SW'((idx + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_sel_q   <= '0;
      ptr_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_sel_q   <= y_sel_d;
      ptr_q     <= ptr_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_sel   = y_sel_q;

endmodule

// File: tb/tb_muxn_rr.sv
// Directed testbench for muxn_rr (WIDTH = 4, N = 4) with hand-computed expectations.
module tb_muxn_rr;

  localparam int WIDTH = 4;
  localparam int N     = 4;
  localparam int SW    = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*WIDTH-1:0] a;
  logic [N-1:0]       valid_in;
  logic               mode;
  logic [SW-1:0]      s;
  logic [N-1:0]       grant;
  logic [WIDTH-1:0]   y;
  logic               y_valid;
  logic [SW-1:0]      y_sel;
  logic               y_ready;

  int n_cmp = 0;
  int n_bad = 0;

  muxn_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .a(a), .valid_in(valid_in), .mode(mode), .s(s),
    .grant(grant), .y(y), .y_valid(y_valid), .y_sel(y_sel), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply current inputs: check grant before the edge, then the registered result.
  task automatic step(input string tag, input logic [N-1:0] exp_grant,
                      input logic exp_v, input logic [SW-1:0] exp_sel,
                      input logic [WIDTH-1:0] exp_y);
    #1;
    chk({tag, " grant"}, 32'(grant), 32'(exp_grant));
    tick();
    chk({tag, " y_valid"}, 32'(y_valid), 32'(exp_v));
    chk({tag, " y_sel"}, 32'(y_sel), 32'(exp_sel));
    chk({tag, " y"}, 32'(y), 32'(exp_y));
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1; a = 16'($urandom); valid_in = 4'($urandom); mode = 1'($urandom);
    s = 2'($urandom); y_ready = 1'($urandom);
    for (int i = 0; i < 2; i++) begin
      step("reset", 4'b0000, 1'b0, 2'd0, 4'h0);
      a = 16'($urandom); valid_in = 4'($urandom); y_ready = 1'($urandom);
    end
    rst = 1'b0; mode = 1'b1; valid_in = 4'b0000; y_ready = 1'b1;
    #1; chk("post-reset grant", 32'(grant), 32'h0);
    tick(); chk("post-reset y_valid", 32'(y_valid), 32'h0);

    // Manual sweep
    mode = 1'b0; a = 16'hDCBA; valid_in = 4'b1111;
    for (int k = 0; k < N; k++) begin
      s = 2'(k);
      step("manual", 4'(1 << k), 1'b1, 2'(k), 4'(4'hA + k));
    end
    s = 2'd2; valid_in = 4'b1011;
    step("manual invalid", 4'b0000, 1'b0, 2'd2, 4'hC);

    // Round-robin, all requesting: 0,1,2,3,0,1,2,3 leaves ptr = 0
    mode = 1'b1; valid_in = 4'b1111;
    for (int k = 0; k < 8; k++)
      step("rr all", 4'(1 << (k % 4)), 1'b1, 2'(k % 4), 4'(4'hA + k % 4));
    valid_in = 4'b1010;
    for (int k = 0; k < 4; k++)
      step("rr 1010", (k % 2 == 0) ? 4'b0010 : 4'b1000, 1'b1,
           (k % 2 == 0) ? 2'd1 : 2'd3, (k % 2 == 0) ? 4'hB : 4'hD);

    // Back-pressure: load A then B, stall 3 cycles, release to channel 2
    valid_in = 4'b1111;
    step("bp load0", 4'b0001, 1'b1, 2'd0, 4'hA);
    step("bp load1", 4'b0010, 1'b1, 2'd1, 4'hB);
    y_ready = 1'b0;
    for (int k = 0; k < 3; k++) step("bp stall", 4'b0000, 1'b1, 2'd1, 4'hB);
    y_ready = 1'b1;
    step("bp release", 4'b0100, 1'b1, 2'd2, 4'hC);

    // Reset mid-stall
    y_ready = 1'b0;
    step("stall pre-rst", 4'b0000, 1'b1, 2'd2, 4'hC);
    rst = 1'b1;
    step("rst mid-stall", 4'b0000, 1'b0, 2'd0, 4'h0);
    rst = 1'b0; y_ready = 1'b1;
    step("after rst rr", 4'b0001, 1'b1, 2'd0, 4'hA);

    // Mode switch: reach ptr = 2, two manual cycles, then back to round-robin
    step("to ptr2", 4'b0010, 1'b1, 2'd1, 4'hB);
    mode = 1'b0; s = 2'd0;
    for (int k = 0; k < 2; k++) step("manual phase", 4'b0001, 1'b1, 2'd0, 4'hA);
    mode = 1'b1;
    step("rr resume", 4'b0100, 1'b1, 2'd2, 4'hC);

    // No requesters: y_valid drops, y and y_sel hold; idle register ignores y_ready = 0
    valid_in = 4'b0000;
    step("rr none", 4'b0000, 1'b0, 2'd2, 4'hC);
    y_ready = 1'b0; valid_in = 4'b0001;
    step("idle not ready", 4'b0001, 1'b1, 2'd0, 4'hA);
    step("stall again", 4'b0000, 1'b1, 2'd0, 4'hA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
